// File: rtl/dram_bitsel_bank_if.sv
// Bus bundle for dram_bitsel_bank.
// master: drives address, write data, bit select, write enable and clear
//         request; observes read data and sweep/status flags.
// slave:  the RAM bank itself.
// Widths: addr is clog2(DEPTH), din/dout are WIDTH, wsel is max(1,clog2(WIDTH)).
interface dram_bitsel_bank_if #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] din;
  logic [SW-1:0]    wsel;
  logic             we;
  logic             clr_req;
  logic [WIDTH-1:0] dout;
  logic             busy;
  logic             wr_drop;
  logic             clr_done;

  modport master (
    output addr, din, wsel, we, clr_req,
    input  dout, busy, wr_drop, clr_done
  );

  modport slave (
    input  addr, din, wsel, we, clr_req,
    output dout, busy, wr_drop, clr_done
  );
endinterface

// File: rtl/dram_bitsel_bank.sv
// Parametrised distributed-RAM bank with full-word or single-bit writes and a
// built-in clear sequencer that sweeps FILL into every word.
// Ports:
//   clk  - write/sequencer clock
//   rst  - asynchronous, active-high reset (array contents are not reset)
//   bus  - slave side of dram_bitsel_bank_if (addr, din, wsel, we, clr_req in;
//          dout, busy, wr_drop, clr_done out)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | user writes accepted, clr_req starts a sweep
// S_CLEAR | ptr walks 0..DEPTH-1 writing FILL, user writes rejected
module dram_bitsel_bank #(
  parameter int               DEPTH        = 64,
  parameter int               WIDTH        = 8,
  parameter int               BITSEL       = 1,
  parameter int               OUT_REG      = 0,
  parameter logic [WIDTH-1:0] FILL         = '0,
  parameter int               CLR_ON_RESET = 1
) (
  input logic               clk,
  input logic               rst,
  dram_bitsel_bank_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;
  localparam state_t RST_STATE = (CLR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  logic [WIDTH-1:0] mem_q [DEPTH];
  state_t           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic             wr_drop_q, wr_drop_d;
  logic             sweep_last, wsel_ok, user_wr;
  logic [WIDTH-1:0] rdata, bmask, wdata;

  assign rdata      = mem_q[bus.addr];
  assign sweep_last = (state_q == S_CLEAR) && (ptr_q == AW'(DEPTH - 1));

  // Select values past the top bit only exist for non-power-of-two widths.
  assign wsel_ok = (BITSEL == 0) || ({1'b0, bus.wsel} < (SW + 1)'(WIDTH));
  assign user_wr = (state_q == S_IDLE) && bus.we && wsel_ok;

  // Single-bit write is a read-modify-write of the addressed word.
  assign bmask = WIDTH'(1) << bus.wsel;
  assign wdata = (BITSEL != 0) ? ((rdata & ~bmask) | ({WIDTH{bus.din[0]}} & bmask))
                               : bus.din;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wr_drop_d = bus.we && !user_wr;
    case (state_q)
      S_IDLE: begin
        if (bus.clr_req) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
        end
      end
      S_CLEAR: begin
        if (sweep_last) begin
          state_d = S_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RST_STATE;
      ptr_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      mem_q[ptr_q] <= FILL;
    end else if (user_wr) begin
      mem_q[bus.addr] <= wdata;
    end
  end

  assign bus.busy     = (state_q == S_CLEAR);
  assign bus.clr_done = sweep_last;
  assign bus.wr_drop  = wr_drop_q;

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [WIDTH-1:0] dout_q;
      // Samples the array before this edge's write lands (read-first).
      always_ff @(posedge clk or posedge rst) begin
        if (rst) dout_q <= '0;
        else     dout_q <= rdata;
      end
      assign bus.dout = dout_q;
    end else begin : g_comb
      assign bus.dout = rdata;
    end
  endgenerate
endmodule

// File: tb/tb_dram_bitsel_bank.sv
module tb_dram_bitsel_bank;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;

  dram_bitsel_bank_if #(.DEPTH(64), .WIDTH(8))  b0 ();
  dram_bitsel_bank_if #(.DEPTH(32), .WIDTH(16)) b1 ();
  dram_bitsel_bank_if #(.DEPTH(16), .WIDTH(6))  b2 ();

  dram_bitsel_bank #(.DEPTH(64), .WIDTH(8), .BITSEL(1), .OUT_REG(0),
                     .FILL(8'h00), .CLR_ON_RESET(1))
    u0 (.clk(clk), .rst(rst0), .bus(b0.slave));
  dram_bitsel_bank #(.DEPTH(32), .WIDTH(16), .BITSEL(0), .OUT_REG(0),
                     .FILL(16'hA5A5), .CLR_ON_RESET(0))
    u1 (.clk(clk), .rst(rst1), .bus(b1.slave));
  dram_bitsel_bank #(.DEPTH(16), .WIDTH(6), .BITSEL(1), .OUT_REG(1),
                     .FILL(6'h00), .CLR_ON_RESET(1))
    u2 (.clk(clk), .rst(rst2), .bus(b2.slave));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [5:0] addr;
    logic [2:0] wsel;
    logic       din;
    logic       we;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [10];

  logic [7:0] m0 [64];
  logic [5:0] m2 [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles until busy drops (bounded) and how many clr_done pulses were seen.
  task automatic run_sweep(input int which, input int last_idx, output int n, output int dones);
    logic bz, dn;
    n = 0;
    dones = 0;
    forever begin
      case (which)
        0:       begin bz = b0.busy; dn = b0.clr_done; end
        1:       begin bz = b1.busy; dn = b1.clr_done; end
        default: begin bz = b2.busy; dn = b2.clr_done; end
      endcase
      if (bz !== 1'b1 || n >= 300) break;
      if (dn === 1'b1) begin
        dones++;
        chk("clr_done_cycle", n, last_idx);
      end
      step();
      n++;
    end
  endtask

  initial begin
    int n, d;
    logic [5:0] a;
    logic [2:0] w;
    logic       bit_d, wen;
    logic [5:0] exp6;
    logic       exp_drop;

    tbl[0] = '{6'd5,  3'd3, 1'b1, 1'b1, 8'h08};
    tbl[1] = '{6'd5,  3'd7, 1'b1, 1'b1, 8'h88};
    tbl[2] = '{6'd4,  3'd0, 1'b1, 1'b0, 8'h00};
    tbl[3] = '{6'd6,  3'd0, 1'b1, 1'b0, 8'h00};
    tbl[4] = '{6'd5,  3'd3, 1'b0, 1'b1, 8'h80};
    tbl[5] = '{6'd5,  3'd3, 1'b1, 1'b0, 8'h80};
    tbl[6] = '{6'd63, 3'd0, 1'b1, 1'b1, 8'h01};
    tbl[7] = '{6'd0,  3'd7, 1'b1, 1'b1, 8'h80};
    tbl[8] = '{6'd5,  3'd7, 1'b0, 1'b1, 8'h00};
    tbl[9] = '{6'd63, 3'd0, 1'b0, 1'b0, 8'h01};

    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    b0.addr = '0; b0.din = '0; b0.wsel = '0; b0.we = 1'b0; b0.clr_req = 1'b0;
    b1.addr = '0; b1.din = '0; b1.wsel = '0; b1.we = 1'b0; b1.clr_req = 1'b0;
    b2.addr = '0; b2.din = '0; b2.wsel = '0; b2.we = 1'b0; b2.clr_req = 1'b0;
    repeat (3) step();

    chk("rst_busy0", b0.busy, 1);
    chk("rst_drop0", b0.wr_drop, 0);
    chk("rst_done0", b0.clr_done, 0);
    chk("rst_busy1", b1.busy, 0);
    chk("rst_busy2", b2.busy, 1);
    chk("rst_dout2", b2.dout, 0);

    // Release: u0 sweeps 64 cycles, u2 16 cycles concurrently.
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    run_sweep(0, 63, n, d);
    chk("sweep0_len", n, 64);
    chk("sweep0_dones", d, 1);
    chk("idle0", b0.busy, 0);
    chk("idle2", b2.busy, 0);

    for (int i = 0; i < 64; i++) begin
      b0.addr = 6'(i);
      #1;
      chk("clear0_read", b0.dout, 8'h00);
    end

    // Table-driven single-bit writes; upper din bits carry junk.
    foreach (tbl[i]) begin
      b0.addr = tbl[i].addr;
      b0.wsel = tbl[i].wsel;
      b0.din  = {7'b1010101, tbl[i].din};
      b0.we   = tbl[i].we;
      step();
      b0.we = 1'b0;
      chk($sformatf("tbl%0d_dout", i), b0.dout, tbl[i].exp);
      chk($sformatf("tbl%0d_drop", i), b0.wr_drop, 0);
    end
    b0.addr = 6'd4; #1; chk("tbl_nb4", b0.dout, 8'h00);
    b0.addr = 6'd6; #1; chk("tbl_nb6", b0.dout, 8'h00);

    // u1: full-word bank with FILL A5A5, clear on request.
    b1.clr_req = 1'b1;
    step();
    b1.clr_req = 1'b0;
    chk("req_busy1", b1.busy, 1);
    run_sweep(1, 31, n, d);
    chk("sweep1_len", n, 32);
    chk("sweep1_dones", d, 1);
    for (int i = 0; i < 32; i++) begin
      b1.addr = 5'(i);
      #1;
      chk("fill1_read", b1.dout, 16'hA5A5);
    end
    b1.addr = 5'd0; b1.din = 16'h1234; b1.we = 1'b1;
    step();
    b1.we = 1'b0;
    chk("word1_write", b1.dout, 16'h1234);

    // Write and clear request together: write lands, then the sweep overwrites it.
    b1.addr = 5'd3; b1.din = 16'h1111; b1.we = 1'b1; b1.clr_req = 1'b1;
    step();
    b1.we = 1'b0; b1.clr_req = 1'b0;
    chk("wc_busy1", b1.busy, 1);
    chk("wc_committed", b1.dout, 16'h1111);
    repeat (5) step();
    b1.clr_req = 1'b1;
    step();
    b1.clr_req = 1'b0;
    run_sweep(1, 25, n, d);
    chk("sweep1_noretrig_len", n, 26);
    chk("sweep1_noretrig_dones", d, 1);
    step();
    chk("noretrig_idle1", b1.busy, 0);
    b1.addr = 5'd3; #1; chk("wc_overwritten", b1.dout, 16'hA5A5);
    b1.addr = 5'd0; #1; chk("w0_overwritten", b1.dout, 16'hA5A5);

    // u0: write at cycle 10 of a sweep is dropped.
    b0.clr_req = 1'b1;
    step();
    b0.clr_req = 1'b0;
    repeat (10) step();
    b0.addr = 6'd5; b0.wsel = 3'd2; b0.din = 8'h01; b0.we = 1'b1;
    #1;
    chk("drop_pre", b0.wr_drop, 0);
    step();
    b0.we = 1'b0;
    chk("drop_pulse", b0.wr_drop, 1);
    step();
    chk("drop_end", b0.wr_drop, 0);
    run_sweep(0, 51, n, d);
    chk("sweep0b_len", n, 52);
    b0.addr = 6'd5;  #1; chk("drop_word5", b0.dout, 8'h00);
    b0.addr = 6'd63; #1; chk("drop_word63", b0.dout, 8'h00);

    // u0: reset at ptr=20 restarts a full 64-cycle sweep.
    b0.clr_req = 1'b1;
    step();
    b0.clr_req = 1'b0;
    repeat (20) step();
    rst0 = 1'b1;
    #1;
    chk("midrst_busy", b0.busy, 1);
    chk("midrst_done", b0.clr_done, 0);
    step();
    rst0 = 1'b0;
    run_sweep(0, 63, n, d);
    chk("midrst_len", n, 64);
    chk("midrst_dones", d, 1);

    // u2: registered read is read-first.
    b2.addr = 4'd9; b2.wsel = 3'd0; b2.din = 6'h01; b2.we = 1'b1;
    step();
    b2.we = 1'b0;
    chk("oreg_old", b2.dout, 6'h00);
    step();
    chk("oreg_new", b2.dout, 6'h01);
    b2.wsel = 3'd7; b2.din = 6'h3F; b2.we = 1'b1;
    step();
    b2.we = 1'b0;
    chk("wsel_oob_drop", b2.wr_drop, 1);
    step();
    chk("wsel_oob_keep", b2.dout, 6'h01);
    chk("wsel_oob_end", b2.wr_drop, 0);

    // u2 randomized against a bit-array model.
    foreach (m2[i]) m2[i] = 6'h00;
    m2[9] = 6'h01;
    for (int i = 0; i < 400; i++) begin
      a = 6'($urandom_range(0, 15));
      w = 3'($urandom_range(0, 7));
      bit_d = 1'($urandom);
      wen = 1'($urandom);
      b2.addr = a[3:0]; b2.wsel = w; b2.din = {5'($urandom), bit_d}; b2.we = wen;
      exp6 = m2[a[3:0]];
      exp_drop = wen && (w >= 3'd6);
      if (wen && w < 3'd6) m2[a[3:0]][w] = bit_d;
      step();
      chk("rnd2_dout", b2.dout, exp6);
      chk("rnd2_drop", b2.wr_drop, exp_drop);
    end
    b2.we = 1'b0;

    // u0 randomized against a bit-array model (array all FILL after reset sweep).
    foreach (m0[i]) m0[i] = 8'h00;
    for (int i = 0; i < 300; i++) begin
      a = 6'($urandom_range(0, 63));
      w = 3'($urandom_range(0, 7));
      bit_d = 1'($urandom);
      wen = 1'($urandom);
      b0.addr = a; b0.wsel = w; b0.din = {7'($urandom), bit_d}; b0.we = wen;
      if (wen) m0[a][w] = bit_d;
      step();
      chk("rnd0_dout", b0.dout, m0[a]);
      chk("rnd0_drop", b0.wr_drop, 0);
    end
    b0.we = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dram_bitsel_bank.md
Name: dram_bitsel_bank

Overview:
- Parametrised distributed-RAM bank, the generalised successor to the fixed 64x8 bit-select LUT-RAM used in the feature tests.
- Configurable depth and width.
- Two write modes: full-word write, or single-bit write steered by a select field.
- Built-in clear sequencer that sweeps the array with a fill pattern after reset or on request.
- Optional registered read port.
- Sits between board switch/LED glue and the LUT-RAM fabric in feature-test tops.

Parameters:
- DEPTH, 64, number of words; power of two, 16..256.
- WIDTH, 8, bits per word; 1..32.
- BITSEL, 1, 1 = single-bit write via wsel/din[0]; 0 = full-word write of din.
- OUT_REG, 0, 0 = combinational read; 1 = read data registered (1-cycle latency).
- FILL, 0, WIDTH-bit pattern written to every word by the clear sequencer.
- CLR_ON_RESET, 1, 1 = run a clear sweep automatically after reset; 0 = start in IDLE.

Ports:
- clk  in  1  write/sequencer clock
- rst  in  1  asynchronous, active-high reset
- addr  in  clog2(DEPTH)  shared read/write address
- din  in  WIDTH  write data; only bit 0 used when BITSEL=1
- wsel  in  max(1,clog2(WIDTH))  bit index for single-bit write; ignored when BITSEL=0
- we  in  1  write enable
- clr_req  in  1  request a clear sweep; single-cycle pulse or level
- dout  out  WIDTH  read data at addr
- busy  out  1  clear sweep in progress
- wr_drop  out  1  one-cycle pulse: a user write was rejected
- clr_done  out  1  one-cycle pulse on the final sweep write

Behaviour:
- One clock; reset is asynchronous and active-high (rst); polarity and synchronicity are fixed.
- Reset values: busy = CLR_ON_RESET, wr_drop = 0, clr_done = 0; registered dout = 0; sweep counter = 0.
- Reset does not touch array contents, which are undefined until a sweep runs.
- States:
  - IDLE: user writes are accepted.
  - CLEAR: counter ptr walks 0..DEPTH-1, writing FILL to mem[ptr], one word per cycle.
  - After rst deasserts: CLEAR if CLR_ON_RESET=1, otherwise IDLE.
- Transitions:
  - IDLE -> CLEAR on clr_req=1 at a clock edge; ptr starts at 0.
  - CLEAR -> IDLE after the write at ptr=DEPTH-1. clr_done pulses high in the cycle that write occurs; busy drops on the following edge.
  - A sweep takes exactly DEPTH cycles.
  - clr_req during CLEAR is ignored; no restart and no queuing.
  - rst during CLEAR aborts the sweep immediately; it restarts from 0 only if CLR_ON_RESET=1.
- User write (IDLE, we=1), at the rising edge:
  - BITSEL=1: mem[addr][wsel] <= din[0]; other bits unchanged.
  - BITSEL=0: mem[addr] <= din.
- wsel >= WIDTH (non-power-of-two WIDTH): write suppressed and wr_drop pulses.
- we=1 while busy=1: write discarded and wr_drop pulses for one cycle.
- we=1 and clr_req=1 in the same IDLE cycle: the user write commits at that edge and the sweep starts next cycle, so the sweep overwrites it.
- Read:
  - OUT_REG=0: dout = mem[addr] combinationally. A write shows on dout after the edge (write-first as seen from the next cycle).
  - OUT_REG=1: dout <= mem[addr] at each edge, using pre-write contents for same-address same-cycle writes (read-first).
- Reads are permitted during CLEAR and return current contents (FILL for addresses already swept).
- Address arithmetic: ptr is clog2(DEPTH) bits; terminal detection is ptr==DEPTH-1, with no wrap to 0 while in CLEAR.

Test Plan:
- Default params, release rst: busy=1 for exactly 64 cycles, clr_done pulses once on the 64th; then read all addresses -> dout=8'h00.
- BITSEL=1, IDLE: write addr=5 wsel=3 din=1, then addr=5 wsel=7 din=1 -> dout at addr 5 = 8'h88; addr 4 and 6 stay 8'h00.
- BITSEL=0, WIDTH=16, FILL=16'hA5A5: clr_req pulse -> all words read 16'hA5A5; write addr=0 din=16'h1234 -> dout=16'h1234.
- we=1 at cycle 10 of a sweep -> wr_drop=1 for one cycle; after the sweep the target word equals FILL.
- Assert rst at ptr=20 mid-sweep, CLR_ON_RESET=1 -> busy stays 1, sweep restarts at 0 and takes 64 further cycles.
- OUT_REG=1: write addr=9 din=1 wsel=0 while reading addr 9 -> dout shows old 8'h00 next cycle, then 8'h01 the cycle after.
